nibble_sort_ctrl: RTL

Sequential sort controller that time-shares a single W-bit magnitude comparator to bubble-sort N packed unsigned elements in place. It sits beside the comparator datapath and sequences it: it selects the operand pair each cycle, reads the one-hot compare result, and decides whether to swap. It uses a start/busy/done handshake so it can be dropped behind any host that loads a vector and waits for the sorted result.

---
 rtl/nibble_sort_ctrl_if.sv | 36 +++
 rtl/nibble_sort_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/nibble_sort_ctrl_if.sv
// nibble_sort_ctrl_if: host <-> sort controller bundle.
// Carries start/ascending/data_in to the sorter; busy/done/data_out/swap_count back.
interface nibble_sort_ctrl_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic           start;
    logic           ascending;
    logic [N*W-1:0] data_in;
    logic           busy;
    logic           done;
    logic [N*W-1:0] data_out;
    logic [7:0]     swap_count;

    // Host side: loads a vector and waits for the sorted result.
    modport master (
        output start,
        output ascending,
        output data_in,
        input  busy,
        input  done,
        input  data_out,
        input  swap_count
    );

    // Sorter side.
    modport slave (
        input  start,
        input  ascending,
        input  data_in,
        output busy,
        output done,
        output data_out,
        output swap_count
    );
endinterface

// File: rtl/nibble_sort_ctrl.sv
// nibble_sort_ctrl: in-place bubble sort of N W-bit unsigned elements using
// one shared comparator. Ports: clk, rst (sync, active-high), bus (slave).
module nibble_sort_ctrl #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                rst,
    nibble_sort_ctrl_if.slave   bus
);

    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST0 = IW'(N - 2);

    typedef enum logic {
        IDLE,
        SORT
    } state_t;

    state_t         state;
    logic [W-1:0]   elem [N];
    logic           order;
    logic [IW-1:0]  pass;
    logic [IW-1:0]  i;
    logic           pass_swaps;
    logic           busy_q;
    logic           done_q;
    logic [7:0]     swaps_q;

    logic [IW-1:0]  ip1;
    logic [IW-1:0]  last_idx;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2:0]     cmp;
    logic           do_swap;

    // Shared comparator: operands are the adjacent pair at index i.
    always_comb begin
        ip1      = i + IW'(1);
        last_idx = LAST0 - pass;
        a        = elem[i];
        b        = elem[ip1];
        cmp      = {a > b, a == b, a < b};
    end

    // Equal operands never swap, which keeps the sort stable.
    always_comb begin
        do_swap = 1'b0;
        unique case (1'b1)
            cmp[2]:  do_swap = order;
            cmp[1]:  do_swap = 1'b0;
            cmp[0]:  do_swap = ~order;
            default: do_swap = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            order      <= 1'b1;
            pass       <= '0;
            i          <= '0;
            pass_swaps <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            swaps_q    <= '0;
            for (int k = 0; k < N; k++) elem[k] <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < N; k++)
                            elem[k] <= bus.data_in[k*W +: W];
                        order      <= bus.ascending;
                        pass       <= '0;
                        i          <= '0;
                        pass_swaps <= 1'b0;
                        swaps_q    <= '0;
                        state      <= SORT;
                        busy_q     <= 1'b1;
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        elem[i]    <= b;
                        elem[ip1]  <= a;
                        swaps_q    <= swaps_q + 8'd1;
                        pass_swaps <= 1'b1;
                    end
                    if (i == last_idx) begin
                        // A clean pass, or the final pass, ends the sort.
                        if (!(pass_swaps || do_swap) || pass == LAST0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            pass       <= pass + IW'(1);
                            i          <= '0;
                            pass_swaps <= 1'b0;
                        end
                    end else begin
                        i <= ip1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.swap_count = swaps_q;

    for (genvar g = 0; g < N; g++) begin : g_out
        assign bus.data_out[g*W +: W] = elem[g];
    end

endmodule
